// File: rtl/risc_fetch_if.sv
// risc_fetch_if: instruction-memory req/gnt/rvalid bus.
// master = fetch stage, slave = instruction memory.
interface risc_fetch_if #(
  parameter int BIT_WIDTH = 32
);
  logic                 imem_req_o;
  logic [BIT_WIDTH-1:0] imem_addr_o;
  logic                 imem_gnt_i;
  logic                 imem_rvalid_i;
  logic [BIT_WIDTH-1:0] imem_rdata_i;

  modport master (
    output imem_req_o,
    output imem_addr_o,
    input  imem_gnt_i,
    input  imem_rvalid_i,
    input  imem_rdata_i
  );

  modport slave (
    input  imem_req_o,
    input  imem_addr_o,
    output imem_gnt_i,
    output imem_rvalid_i,
    output imem_rdata_i
  );
endinterface

// File: rtl/risc_fetch.sv
// risc_fetch: RV32I fetch stage, single outstanding imem request, skid buffer.
// Optional FETCH_MISALIGN_TRAP_EN: halt and flag misaligned redirect targets.
module risc_fetch #(
  parameter int                   BIT_WIDTH = 32,
  parameter logic [BIT_WIDTH-1:0] RESET_PC  = 32'h0000_0000,
  parameter logic [BIT_WIDTH-1:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 stall_i,
  input  logic                 redirect_i,
  input  logic [BIT_WIDTH-1:0] target_i,
  risc_fetch_if.master         imem,
  output logic [BIT_WIDTH-1:0] instr_o,
  output logic [BIT_WIDTH-1:0] pc_o,
  output logic                 valid_o,
  output logic                 misalign_o
);

  typedef enum logic [2:0] {
    S_RST,
    S_REQ,
    S_WAIT,
`ifdef FETCH_MISALIGN_TRAP_EN
    S_HALT,
`endif
    S_HOLD
  } state_t;

  state_t               state_q;
  logic [BIT_WIDTH-1:0] pc_q;
  logic [BIT_WIDTH-1:0] instr_q;
  logic [BIT_WIDTH-1:0] pc_out_q;
  logic                 valid_q;
  logic [BIT_WIDTH-1:0] skid_instr_q;
  logic [BIT_WIDTH-1:0] skid_pc_q;
  logic                 discard_q;

  logic [BIT_WIDTH-1:0] tgt;
  logic                 mis;
  logic [BIT_WIDTH-1:0] pc_inc;
  logic                 accept;
  logic                 take;
  logic                 req;
  logic                 pending;

  // Redirect target: full address with trap, word-aligned without.
  always_comb begin
    tgt = {target_i[BIT_WIDTH-1:2], 2'b00};
    mis = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    tgt = target_i;
    mis = |target_i[1:0];
`endif
  end

`ifndef FETCH_MISALIGN_TRAP_EN
  logic unused_tgt_lsb;
  assign unused_tgt_lsb = ^target_i[1:0];
`endif

  // Request issue; the early request keeps zero-wait memory at 1 IPC.
  always_comb begin
    pc_inc  = pc_q + BIT_WIDTH'(4);
    accept  = !valid_q || !stall_i;
    take    = (state_q == S_WAIT) && imem.imem_rvalid_i
              && !discard_q && !redirect_i && accept;
    req     = (state_q == S_REQ) || take;
    pending = ((state_q == S_WAIT) && !imem.imem_rvalid_i)
              || (discard_q && !imem.imem_rvalid_i)
              || (req && imem.imem_gnt_i);
  end

  assign imem.imem_req_o  = req;
  assign imem.imem_addr_o = take ? pc_inc : pc_q;
  assign instr_o          = instr_q;
  assign pc_o             = pc_out_q;
  assign valid_o          = valid_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic misalign_q;
  assign misalign_o = misalign_q;
`else
  assign misalign_o = 1'b0;
`endif

  // Fetch FSM, PC, IF/ID register and skid buffer.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_RST;
      pc_q         <= RESET_PC;
      instr_q      <= NOP_INSTR;
      pc_out_q     <= '0;
      valid_q      <= 1'b0;
      skid_instr_q <= NOP_INSTR;
      skid_pc_q    <= '0;
      discard_q    <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q   <= 1'b0;
`endif
    end else if (redirect_i) begin
      pc_q      <= tgt;
      valid_q   <= 1'b0;
      instr_q   <= NOP_INSTR;
      discard_q <= pending;
      state_q   <= pending ? S_WAIT : S_REQ;
`ifdef FETCH_MISALIGN_TRAP_EN
      misalign_q <= mis;
      if (mis) state_q <= S_HALT;
`endif
    end else begin
      if (!stall_i) begin
        valid_q <= 1'b0;
        instr_q <= NOP_INSTR;
      end
      unique case (state_q)
        S_RST: state_q <= S_REQ;
        S_REQ: begin
          if (imem.imem_gnt_i) state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (imem.imem_rvalid_i) begin
            if (discard_q) begin
              discard_q <= 1'b0;
              state_q   <= S_REQ;
            end else if (accept) begin
              instr_q  <= imem.imem_rdata_i;
              pc_out_q <= pc_q;
              valid_q  <= 1'b1;
              pc_q     <= pc_inc;
              state_q  <= imem.imem_gnt_i ? S_WAIT : S_REQ;
            end else begin
              skid_instr_q <= imem.imem_rdata_i;
              skid_pc_q    <= pc_q;
              pc_q         <= pc_inc;
              state_q      <= S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall_i) begin
            instr_q  <= skid_instr_q;
            pc_out_q <= skid_pc_q;
            valid_q  <= 1'b1;
            state_q  <= S_REQ;
          end
        end
`ifdef FETCH_MISALIGN_TRAP_EN
        S_HALT: begin
          if (imem.imem_rvalid_i) discard_q <= 1'b0;
        end
`endif
        default: state_q <= S_RST;
      endcase
    end
  end

  // Keep mis referenced in the default build.
  logic unused_mis;
  assign unused_mis = mis;

endmodule

// File: tb/tb_risc_fetch.sv
// tb_risc_fetch: directed bench for risc_fetch with a delay-configurable imem.
// Memory returns addr ^ 32'hA000_0000 so instr and pc are distinguishable.
module tb_risc_fetch;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] target = '0;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        valid;
  logic        misalign;

  int checks = 0;
  int errors = 0;

  int          gnt_dly = 0;
  int          rv_dly = 1;
  int          req_cnt;
  int          outst;
  int          pcnt;
  logic        pend;
  logic [31:0] paddr;
  logic        rv_r;
  logic [31:0] rd_r;

  risc_fetch_if #(.BIT_WIDTH(32)) bus ();

  risc_fetch dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .stall_i    (stall),
    .redirect_i (redirect),
    .target_i   (target),
    .imem       (bus),
    .instr_o    (instr),
    .pc_o       (pc),
    .valid_o    (valid),
    .misalign_o (misalign)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  assign bus.imem_gnt_i    = bus.imem_req_o && (req_cnt >= gnt_dly);
  assign bus.imem_rvalid_i = rv_r;
  assign bus.imem_rdata_i  = rd_r;

  // Instruction memory model with grant and read-data latency.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rv_r <= 1'b0; rd_r <= '0; pend <= 1'b0; paddr <= '0;
      pcnt <= 0; req_cnt <= 0; outst <= 0;
    end else begin
      rv_r <= 1'b0;
      if (pend) begin
        if (pcnt == 1) begin
          rv_r <= 1'b1; rd_r <= tag(paddr); pend <= 1'b0;
        end else pcnt <= pcnt - 1;
      end
      if (bus.imem_req_o && bus.imem_gnt_i) begin
        req_cnt <= 0;
        if (rv_dly == 1) begin
          rv_r <= 1'b1; rd_r <= tag(bus.imem_addr_o);
        end else begin
          pend <= 1'b1; paddr <= bus.imem_addr_o; pcnt <= rv_dly - 1;
        end
      end else if (bus.imem_req_o) req_cnt <= req_cnt + 1;
      else req_cnt <= 0;
      if (bus.imem_req_o && bus.imem_gnt_i && !rv_r) outst <= outst + 1;
      else if (!(bus.imem_req_o && bus.imem_gnt_i) && rv_r) outst <= outst - 1;
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", bus.imem_req_o); end
    checks++; if (bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", bus.imem_addr_o); end
    checks++; if (instr !== 32'h13) begin errors++; $display("FAIL reset_instr got %h want 00000013", instr); end
    checks++; if (pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", pc); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL reset_misalign got %b want 0", misalign); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h0) begin errors++; $display("FAIL first_req got %b/%h want 1/0", bus.imem_req_o, bus.imem_addr_o); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL early_valid1 got %b want 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL early_valid2 got %b want 0", valid); end
  endtask

  task automatic test_stream();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || pc !== 32'(4 * i) || instr !== tag(32'(4 * i))) begin
        errors++; $display("FAIL stream[%0d] got v=%b pc=%h i=%h want 1 %h %h", i, valid, pc, instr, 32'(4 * i), tag(32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (valid !== 1'b1 || pc !== 32'd12 || instr !== tag(32'd12)) begin
        errors++; $display("FAIL stall_hold[%0d] got v=%b pc=%h i=%h want 1 0000000c %h", i, valid, pc, instr, tag(32'd12));
      end
      checks++; if (bus.imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_noreq[%0d] got %b want 0", i, bus.imem_req_o); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== 32'd16 || instr !== tag(32'd16)) begin
      errors++; $display("FAIL skid_out got v=%b pc=%h i=%h want 1 00000010 %h", valid, pc, instr, tag(32'd16));
    end
    checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'd20) begin
      errors++; $display("FAIL skid_req got %b/%h want 1/00000014", bus.imem_req_o, bus.imem_addr_o);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL skid_gap got %b want 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== 32'd20 || instr !== tag(32'd20)) begin
      errors++; $display("FAIL after_stall got v=%b pc=%h i=%h want 1 00000014 %h", valid, pc, instr, tag(32'd20));
    end
  endtask

  task automatic test_redirect(input string nm, input logic [31:0] t);
    logic [31:0] n;
    n = t + 32'd4;
    redirect = 1'b1; target = t;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (valid !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== t) begin
      errors++; $display("FAIL %s_flush got v=%b req=%b a=%h want 0 1 %h", nm, valid, bus.imem_req_o, bus.imem_addr_o, t);
    end
    @(negedge clk);
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL %s_gap got %b want 0", nm, valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== t || instr !== tag(t)) begin
      errors++; $display("FAIL %s_first got v=%b pc=%h i=%h want 1 %h %h", nm, valid, pc, instr, t, tag(t));
    end
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== n || instr !== tag(n)) begin
      errors++; $display("FAIL %s_next got v=%b pc=%h i=%h want 1 %h %h", nm, valid, pc, instr, n, tag(n));
    end
  endtask

  task automatic test_misalign();
    redirect = 1'b1; target = 32'h102;
    @(negedge clk);
    redirect = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
    for (int i = 0; i < 3; i++) begin
      checks++; if (misalign !== 1'b1 || bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin
        errors++; $display("FAIL halt[%0d] got mis=%b req=%b v=%b want 1 0 0", i, misalign, bus.imem_req_o, valid);
      end
      @(negedge clk);
    end
    redirect = 1'b1; target = 32'h200;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (misalign !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h200) begin
      errors++; $display("FAIL unhalt got mis=%b req=%b a=%h want 0 1 00000200", misalign, bus.imem_req_o, bus.imem_addr_o);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== 32'h200 || instr !== tag(32'h200)) begin
      errors++; $display("FAIL unhalt_first got v=%b pc=%h want 1 00000200", valid, pc);
    end
`else
    checks++; if (misalign !== 1'b0 || bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== 32'h100) begin
      errors++; $display("FAIL align_force got mis=%b req=%b a=%h want 0 1 00000100", misalign, bus.imem_req_o, bus.imem_addr_o);
    end
    @(negedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b1 || pc !== 32'h100 || instr !== tag(32'h100) || misalign !== 1'b0) begin
      errors++; $display("FAIL align_first got v=%b pc=%h mis=%b want 1 00000100 0", valid, pc, misalign);
    end
`endif
  endtask

  task automatic test_delayed();
    int          k;
    int          first;
    logic        p_req;
    logic        p_gnt;
    logic [31:0] p_addr;
    logic        found;
    k = 0; first = -1; p_req = 1'b0; p_gnt = 1'b0; p_addr = '0;
    gnt_dly = 2; rv_dly = 3;
    redirect = 1'b1; target = 32'h400;
    @(negedge clk);
    redirect = 1'b0;
    for (int c = 1; c <= 80 && k < 3; c++) begin
      if (c > 1) @(negedge clk);
      checks++; if (outst > 1) begin errors++; $display("FAIL outstanding c=%0d got %0d want <=1", c, outst); end
      if (p_req && !p_gnt) begin
        checks++; if (bus.imem_req_o !== 1'b1 || bus.imem_addr_o !== p_addr) begin
          errors++; $display("FAIL addr_stable c=%0d got %b/%h want 1/%h", c, bus.imem_req_o, bus.imem_addr_o, p_addr);
        end
      end
      if (valid === 1'b1) begin
        checks++; if (pc !== 32'h400 + 32'(4 * k) || instr !== tag(32'h400 + 32'(4 * k))) begin
          errors++; $display("FAIL slow_word[%0d] got pc=%h i=%h want %h", k, pc, instr, 32'h400 + 32'(4 * k));
        end
        if (k == 0) first = c;
        k++;
      end
      p_req = bus.imem_req_o; p_gnt = bus.imem_gnt_i; p_addr = bus.imem_addr_o;
    end
    checks++; if (k != 3) begin errors++; $display("FAIL slow_timeout got %0d words want 3", k); end
    checks++; if (first != 7) begin errors++; $display("FAIL slow_latency got %0d want 7", first); end
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (bus.imem_req_o && bus.imem_gnt_i && !bus.imem_rvalid_i) found = 1'b1;
    end
    checks++; if (!found) begin errors++; $display("FAIL grant_search got none want grant"); end
    redirect = 1'b1; target = 32'h500;
    @(negedge clk);
    redirect = 1'b0;
    checks++; if (bus.imem_req_o !== 1'b0 || valid !== 1'b0) begin
      errors++; $display("FAIL discard_wait got req=%b v=%b want 0 0", bus.imem_req_o, valid);
    end
    k = 0;
    for (int c = 0; c < 60 && k == 0; c++) begin
      @(negedge clk);
      checks++; if (outst > 1) begin errors++; $display("FAIL discard_outst got %0d want <=1", outst); end
      if (valid === 1'b1) begin
        k = 1;
        checks++; if (pc !== 32'h500 || instr !== tag(32'h500)) begin
          errors++; $display("FAIL discard_word got pc=%h i=%h want 00000500 %h", pc, instr, tag(32'h500));
        end
      end
    end
    checks++; if (k != 1) begin errors++; $display("FAIL discard_timeout got none want word"); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect("redir", 32'h100);
    test_redirect("wrap", 32'hFFFF_FFFC);
    test_misalign();
    test_delayed();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/risc_fetch.md
# risc_fetch

Instruction-fetch stage of the 3-stage RV32I pipeline. Owns the program counter, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and presents the fetched word plus its PC in an IF/ID register to `risc_dec`. Handles decode-side stalls with a one-entry skid buffer and discards in-flight fetches on branch/jump redirect.

## Interface
- `RESET_PC`, 32'h0000_0000, PC fetched first after reset
- `NOP_INSTR`, 32'h0000_0013, value driven on `instr_o` when not valid (addi x0,x0,0)
- `clk_i` in 1: clock, rising edge
- `rst_i` in 1: reset; one clock; reset is asynchronous and active-high
- `stall_i` in 1: decode cannot accept; hold IF/ID register
- `redirect_i` in 1: taken branch/jump from execute
- `target_i` in `BIT_WIDTH`: redirect PC
- `imem_req_o` out 1: fetch request
- `imem_addr_o` out `BIT_WIDTH`: fetch address, stable while `imem_req_o`=1 and no `imem_gnt_i`
- `imem_gnt_i` in 1: request accepted
- `imem_rvalid_i` in 1: read data valid, one per grant
- `imem_rdata_i` in `BIT_WIDTH`: instruction word
- `instr_o` out `BIT_WIDTH`: to `risc_dec` `instr_i`
- `pc_o` out `BIT_WIDTH`: PC of `instr_o`
- `valid_o` out 1: `instr_o`/`pc_o` hold a real instruction
- `misalign_o` out 1: misaligned redirect target trap

## Operation
- States: RST, REQ, WAIT, HOLD, HALT (HALT only with `FETCH_MISALIGN_TRAP_EN`).
- RST: no request; next state REQ. Entered only by reset.
- REQ: `imem_req_o`=1, `imem_addr_o`=pc. On `imem_gnt_i` -> WAIT.
- WAIT: at most one outstanding. On `imem_rvalid_i`: if discard flag set, drop data, clear flag, -> REQ; else if `valid_o`=0 or `stall_i`=0, load IF/ID (`instr_o`=rdata, `pc_o`=pc, `valid_o`=1), pc += 4, and assert `imem_req_o` same cycle at pc+4 (gnt -> stay WAIT, else -> REQ); else load skid buffer, pc += 4, -> HOLD.
- HOLD: no request. When `stall_i`=0, skid -> IF/ID, -> REQ.
- IF/ID with `stall_i`=1 holds. With `stall_i`=0 and no new data, `valid_o`<=0, `instr_o`<=`NOP_INSTR`.
- Redirect (priority over stall and all data): pc<=target, `valid_o`<=0, `instr_o`<=NOP, skid invalidated; if a grant is outstanding (WAIT, or gnt this cycle) set discard flag, -> WAIT, else -> REQ. Redirect in REQ without gnt changes `imem_addr_o` next cycle (permitted: request not yet accepted).
- PC arithmetic modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 0.

## Timing
- Reset values: `imem_req_o`=0, `imem_addr_o`=`RESET_PC`, `instr_o`=NOP, `pc_o`=0, `valid_o`=0, `misalign_o`=0, state RST, discard 0, skid empty.
- Reset mid-transaction: outstanding rvalid after reset release is ignored unless in WAIT; bench keeps memory quiet during reset.
- `imem_gnt_i` may coincide with `imem_req_o`; `imem_rvalid_i` earliest one cycle after gnt.
- Zero-wait memory: first `valid_o` 3 cycles after reset release; then one instruction per cycle.
- Redirect-to-`valid_o` latency with zero-wait memory: 2 cycles.

## Configuration
- `FETCH_MISALIGN_TRAP_EN` defined: redirect with `target_i[1:0]`!=0 -> pc<=target, flush as above, state HALT; HALT issues no requests, holds `misalign_o`=1 until next aligned redirect (then -> REQ, `misalign_o`<=0). Outstanding data discarded.
- Not defined: `target_i[1:0]` forced to 2'b00, `misalign_o` tied 0, no HALT state.

## Test plan
- Reset release, zero-wait memory returning addr as data -> `valid_o` high cycle 3, `pc_o` 0,4,8,12 on consecutive cycles, `instr_o` matches.
- `stall_i`=1 for 3 cycles while a fetch is outstanding -> IF/ID held, next word in skid, no request in HOLD, both words delivered in order after release, no loss/duplication.
- `redirect_i` with target 32'h100 while in WAIT -> returning word dropped, `valid_o`=0 for 2 cycles, next `pc_o`=32'h100.
- Memory with gnt delayed 2 cycles and rvalid delayed 3 -> `imem_addr_o` stable while pending, one outstanding max.
- Redirect to 32'hFFFF_FFFC -> `pc_o` sequence FFFF_FFFC, 0000_0000.
- With macro, redirect to 32'h102 -> `misalign_o`=1, `imem_req_o`=0 until redirect to 32'h200 clears it; without macro fetch proceeds from 32'h100.
